// File: rtl/seq_muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_muldiv_unit_if
// Description : Request/result bundle for the sequential multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             i_start;
    logic [1:0]       i_op;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_hi;
    logic [WIDTH-1:0] o_lo;
    logic             o_div0;
    logic             o_zf;

    modport slave (
        input  i_start, i_op, i_a, i_b,
        output o_busy, o_done, o_hi, o_lo, o_div0, o_zf
    );

    modport master (
        output i_start, i_op, i_a, i_b,
        input  o_busy, o_done, o_hi, o_lo, o_div0, o_zf
    );
endinterface
`default_nettype wire

// File: rtl/seq_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : seq_muldiv_unit
// Description : One-bit-per-clock signed/unsigned multiply and restoring divide
//               with HI/LO result registers.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    seq_muldiv_unit_if.slave       bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic             r_is_div;
    logic             r_is_div0;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;
    logic             r_div0;
    logic             r_zf;

    logic             w_sa;
    logic             w_sb;
    logic             w_div_zero;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH-1:0] w_rem_diff;
    logic             w_rem_ge;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0] w_fix_hi;
    logic [WIDTH-1:0] w_fix_lo;

    always_comb begin
        w_sa       = bus.i_op[0] & bus.i_a[WIDTH-1];
        w_sb       = bus.i_op[0] & bus.i_b[WIDTH-1];
        w_mag_a    = w_sa ? -bus.i_a : bus.i_a;
        w_mag_b    = w_sb ? -bus.i_b : bus.i_b;
        w_div_zero = bus.i_op[1] && (bus.i_b == '0);

        // Multiply: add B into the upper half, keeping the carry for the shift
        w_mul_sum  = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_b} : '0);

        // Divide: partial remainder needs one extra bit after the left shift
        w_rem_sh   = {r_acc_hi, r_acc_lo[WIDTH-1]};
        w_rem_ge   = (w_rem_sh >= {1'b0, r_b});
        w_rem_diff = w_rem_sh[WIDTH-1:0] - r_b;

        w_prod_fix = r_neg_q ? -{r_acc_hi, r_acc_lo} : {r_acc_hi, r_acc_lo};
        if (r_is_div) begin
            w_fix_hi = r_neg_r ? -r_acc_hi : r_acc_hi;
            w_fix_lo = r_neg_q ? -r_acc_lo : r_acc_lo;
        end else begin
            w_fix_hi = w_prod_fix[2*WIDTH-1:WIDTH];
            w_fix_lo = w_prod_fix[WIDTH-1:0];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.i_start) begin
                    w_state_nxt = w_div_zero ? S_FIX : S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == CW'(1)) begin
                    w_state_nxt = S_FIX;
                end
            end
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_is_div  <= 1'b0;
            r_is_div0 <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_acc_hi  <= '0;
            r_acc_lo  <= '0;
            r_b       <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
            r_div0    <= 1'b0;
            r_zf      <= 1'b1;
        end else begin
            r_done <= (r_state == S_FIX);
            case (r_state)
                S_IDLE: begin
                    if (bus.i_start) begin
                        r_is_div  <= bus.i_op[1];
                        r_is_div0 <= w_div_zero;
                        r_div0    <= 1'b0;
                        if (w_div_zero) begin
                            // Result is preloaded so FIX passes it through untouched
                            r_cnt    <= '0;
                            r_neg_q  <= 1'b0;
                            r_neg_r  <= 1'b0;
                            r_b      <= bus.i_b;
                            r_acc_hi <= bus.i_a;
                            r_acc_lo <= '1;
                        end else begin
                            r_cnt    <= CW'(WIDTH);
                            r_neg_q  <= w_sa ^ w_sb;
                            r_neg_r  <= w_sa;
                            r_b      <= w_mag_b;
                            r_acc_hi <= '0;
                            r_acc_lo <= w_mag_a;
                        end
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_is_div) begin
                        if (w_rem_ge) begin
                            r_acc_hi <= w_rem_diff;
                            r_acc_lo <= {r_acc_lo[WIDTH-2:0], 1'b1};
                        end else begin
                            r_acc_hi <= w_rem_sh[WIDTH-1:0];
                            r_acc_lo <= {r_acc_lo[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        r_acc_hi <= w_mul_sum[WIDTH:1];
                        r_acc_lo <= {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
                    end
                end
                S_FIX: begin
                    r_hi   <= w_fix_hi;
                    r_lo   <= w_fix_lo;
                    r_zf   <= ({w_fix_hi, w_fix_lo} == '0);
                    r_div0 <= r_is_div0;
                end
                default: ;
            endcase
        end
    end

    assign bus.o_busy = (r_state != S_IDLE);
    assign bus.o_done = r_done;
    assign bus.o_hi   = r_hi;
    assign bus.o_lo   = r_lo;
    assign bus.o_div0 = r_div0;
    assign bus.o_zf   = r_zf;

endmodule
`default_nettype wire

// File: doc/seq_muldiv_unit.md
# seq_muldiv_unit

Parametrised sequential multiply/divide unit that replaces the single-cycle `*`, `/` and `%` paths of the datapath ALU. It computes signed and unsigned multiply and divide over WIDTH bits with a shift/add or restoring-subtract iteration, one bit per clock. Results are held in internal HI/LO registers that drive the MFHI/MFLO paths. The block sits beside the ALU in the EX stage, and the pipeline stalls on OUT_BUSY.

## Interface
- WIDTH, 32: operand width; HI and LO are each WIDTH bits; must be ≥ 4.
- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- IN_START  in  1  request; sampled only while OUT_BUSY=0.
- IN_OP  in  2  operation: 00 MULTU, 01 MULT (signed), 10 DIVU, 11 DIV (signed).
- IN_A  in  WIDTH  multiplicand or dividend; sampled with IN_START.
- IN_B  in  WIDTH  multiplier or divisor; sampled with IN_START.
- OUT_BUSY  out  1  high while an operation is in flight.
- OUT_DONE  out  1  one-cycle pulse; HI/LO are valid in the same cycle.
- OUT_HI  out  WIDTH  product upper half, or remainder.
- OUT_LO  out  WIDTH  product lower half, or quotient.
- OUT_DIV0  out  1  set on divide-by-zero completion; cleared on the next accepted START.
- OUT_ZF  out  1  registered flag, high when {HI,LO}==0; updated with HI/LO.

## Operation
- States: IDLE, RUN, FIX.
- IDLE
  - IN_START=1 latches op, IN_A, IN_B.
  - Signed ops: latch magnitudes |A| and |B| as WIDTH-bit unsigned values, plus neg_q = sA^sB and neg_r = sA.
  - Unsigned ops: neg_q = neg_r = 0.
  - Load counter = WIDTH, set OUT_BUSY, go to RUN.
- Divide by zero (IN_B==0 on a divide op): skip RUN and go straight to FIX. Result: HI = IN_A unmodified, LO = all ones, OUT_DIV0 = 1, no sign correction.
- RUN, multiply: 2·WIDTH accumulator {P_hi, P_lo}. Each cycle, if P_lo[0]=1 then P_hi += B with carry. Then shift the accumulator right by one with carry-in.
- RUN, divide: restoring division. Shift {R, Q} left one. If R ≥ B, then R -= B and Q[0] = 1.
- RUN: counter decrements every cycle. When the counter reaches 1, go to FIX.
- FIX
  - Apply sign correction: product negated in 2·WIDTH two's complement if neg_q; quotient negated if neg_q; remainder negated if neg_r.
  - Write HI/LO and OUT_ZF.
  - Pulse OUT_DONE, clear OUT_BUSY, return to IDLE.
- Overflow: signed most-negative ÷ −1 wraps, giving LO = 100…0 and HI = 0. This needs no special case.
- Arithmetic is modulo 2^WIDTH per half. The remainder magnitude is always < |B|.
- HI, LO, OUT_ZF and OUT_DIV0 hold their values until the next FIX or reset.
- IN_START while OUT_BUSY=1 is ignored; no queueing. IN_OP, IN_A and IN_B may change freely after acceptance.

## Timing
- START is sampled at edge E0.
- Normal op: RUN occupies edges E1..E_WIDTH and FIX is at edge E_WIDTH+1.
- OUT_DONE, new HI/LO and OUT_ZF are visible after E_WIDTH+1. Latency is WIDTH+1 cycles.
- Divide by zero: FIX at E1, DONE after E1. Latency is 1 cycle.
- OUT_BUSY is high after E0 and low after the FIX edge.
- A new START may be asserted in the cycle where OUT_DONE=1, giving back-to-back throughput of one op per WIDTH+1 cycles.
- Reset values (immediately on RST_N low, regardless of clock):
  - state IDLE, counter 0
  - OUT_BUSY 0, OUT_DONE 0
  - OUT_HI 0, OUT_LO 0
  - OUT_DIV0 0, OUT_ZF 1
- Reset mid-operation aborts the operation. No DONE is produced and HI/LO read 0 after release.
- First START is accepted on the first rising edge with RST_N high.

## Test plan
- MULTU, WIDTH=32, A=B=0xFFFFFFFF:
  - OUT_DONE exactly 33 cycles after START.
  - HI=0xFFFFFFFE, LO=0x00000001, ZF=0.
- MULT A=−3 (0xFFFFFFFD), B=5: HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- MULT A=0, B=0x12345678: HI=LO=0, ZF=1.
- DIV A=−7, B=2: LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1).
- DIV A=0x80000000, B=0xFFFFFFFF: LO=0x80000000, HI=0, DIV0=0.
- DIVU A=0x1234, B=0:
  - DONE 1 cycle after START.
  - HI=0x1234, LO=0xFFFFFFFF, DIV0=1.
  - DIV0 clears at the next accepted START.
- Busy and reset handling:
  - Pulse START again mid-RUN: ignored; result equals the first op's result; exactly one DONE.
  - Assert RST_N low at cycle 10 of a run: BUSY drops immediately and no DONE occurs.
  - After release, HI=LO=0; a fresh op completes correctly.
- Back-to-back: START in the DONE cycle with DIVU 100/7 → the next DONE 33 cycles later with LO=14, HI=2.
- Parameter sweep with WIDTH=8: MULT −128×−128 gives HI=0x40, LO=0x00 and DONE after 9 cycles.
